cymometer_multi: RTL and testbench

- Parametrised successor to the single-channel equal-precision frequency meter.
- Measures CH_NUM external signals in parallel, entirely in the sys_clk domain. Each channel is oversampled and uses its own edge-aligned gate.
- At the end of every measurement period, one shared sequential restoring divider converts the counts to Hz. It processes the channels round-robin.
- Sits between the input pins and the LCD character/display logic.

---
 rtl/cymometer_multi.sv | 210 +++++++++++++++++++++
 tb/tb_cymometer_multi.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cymometer_multi.sv
// cymometer_multi: CH_NUM-channel equal-precision frequency meter in the sys_clk domain.
// Each channel gets a 2-FF synchroniser, an edge-aligned gate and saturating fx/fs counters.
// At the end of each period one shared restoring divider converts the snapshots to Hz,
// channel by channel in ascending order.
// Optional build macro CYMO_ROUND_EN: round-to-nearest quotient instead of truncation.
module cymometer_multi #(
  parameter int unsigned CH_NUM        = 4,
  parameter int unsigned CLK_FS_FREQ   = 50_000_000,
  parameter int unsigned GATE_CYCLES   = 50_000_000,
  parameter int unsigned PERIOD_CYCLES = 62_500_000,
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned DIV_W         = 64,
  parameter int unsigned FREQ_W        = 32
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [CH_NUM-1:0] clk_fx,
  output logic [FREQ_W-1:0] freq_data,
  output logic [3:0]        freq_ch,
  output logic              freq_vld,
  output logic              freq_err,
  output logic              busy
);

  localparam int unsigned PER_W = $clog2(PERIOD_CYCLES);
  localparam int unsigned IDX_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int unsigned BIT_W = $clog2(DIV_W);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StDiv  = 2'd2;
  localparam logic [1:0] StOut  = 2'd3;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [PER_W-1:0]  r_per_cnt;
  logic [CH_NUM-1:0] r_sync1, r_sync2, r_sync3;
  logic [CH_NUM-1:0] r_open, r_done, r_snap_done;
  logic [CNT_W-1:0]  r_cnt_x [CH_NUM];
  logic [CNT_W-1:0]  r_cnt_s [CH_NUM];
  logic [CNT_W-1:0]  r_snap_x [CH_NUM];
  logic [CNT_W-1:0]  r_snap_s [CH_NUM];
  logic [1:0]        r_state;
  logic [3:0]        r_ch;
  logic [BIT_W-1:0]  r_bit;
  logic [DIV_W-1:0]  r_dvd;  // dividend shifts out of the top, quotient shifts in at the bottom
  logic [CNT_W-1:0]  r_rem;
  logic [CNT_W-1:0]  r_dvs;
  logic              r_err;
  logic [FREQ_W-1:0] r_freq_data;
  logic [3:0]        r_freq_ch;
  logic              r_freq_err;

  logic              w_snap, w_soft_gate;
  logic [CH_NUM-1:0] w_fx_rise;
  logic [IDX_W-1:0]  w_idx;
  logic [DIV_W-1:0]  w_prod, w_dividend, w_quo_nxt, w_quo_hi;
  logic [CNT_W:0]    w_rem_sh;
  logic              w_qbit;
  logic [CNT_W-1:0]  w_rem_nxt;
  logic [FREQ_W-1:0] w_freq;

  assign w_snap      = (r_per_cnt == PER_W'(PERIOD_CYCLES - 1));
  assign w_soft_gate = (r_per_cnt < PER_W'(GATE_CYCLES));
  assign w_fx_rise   = r_sync2 & ~r_sync3;
  assign w_idx       = r_ch[IDX_W-1:0];
  assign w_prod      = DIV_W'(CLK_FS_FREQ) * DIV_W'(r_snap_x[w_idx]);
`ifdef CYMO_ROUND_EN
  assign w_dividend  = w_prod + DIV_W'(r_snap_s[w_idx] >> 1);
`else
  assign w_dividend  = w_prod;
`endif

  // One restoring step; the remainder is always below the divisor so its low bits suffice.
  assign w_rem_sh  = {r_rem, r_dvd[DIV_W-1]};
  assign w_qbit    = (w_rem_sh >= {1'b0, r_dvs});
  assign w_rem_nxt = w_rem_sh[CNT_W-1:0] - (w_qbit ? r_dvs : '0);
  assign w_quo_nxt = {r_dvd[DIV_W-2:0], w_qbit};
  assign w_quo_hi  = w_quo_nxt >> FREQ_W;
  assign w_freq    = (|w_quo_hi) ? '1 : w_quo_nxt[FREQ_W-1:0];

  assign freq_data = r_freq_data;
  assign freq_ch   = r_freq_ch;
  assign freq_err  = r_freq_err;
  assign freq_vld  = (r_state == StOut);
  assign busy      = (r_state != StIdle);

  // Free-running measurement period counter.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n || w_snap) r_per_cnt <= '0;
    else                      r_per_cnt <= r_per_cnt + PER_W'(1);
  end

  // Input synchronisers plus one extra stage for rising-edge detection.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_sync3 <= '0;
    end else begin
      r_sync1 <= clk_fx;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // Per-channel gate: opens and closes on fx edges, so fs counts whole fx periods.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_open <= '0;
      r_done <= '0;
      for (int i = 0; i < CH_NUM; i++) begin
        r_cnt_x[i] <= '0;
        r_cnt_s[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (w_snap) begin
          r_open[i] <= 1'b0;
          r_done[i] <= 1'b0;
        end else if (r_open[i]) begin
          r_cnt_s[i] <= sat_inc(r_cnt_s[i]);
          if (w_fx_rise[i]) begin
            r_cnt_x[i] <= sat_inc(r_cnt_x[i]);
            if (!w_soft_gate) begin
              r_open[i] <= 1'b0;
              r_done[i] <= 1'b1;
            end
          end
        end else if (!r_done[i] && w_fx_rise[i] && w_soft_gate) begin
          r_open[i]  <= 1'b1;
          r_cnt_x[i] <= '0;
          r_cnt_s[i] <= '0;
        end
      end
    end
  end

  // Snapshot at period end; dropped while a previous sequence is still running.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_snap_done <= '0;
      for (int i = 0; i < CH_NUM; i++) begin
        r_snap_x[i] <= '0;
        r_snap_s[i] <= '0;
      end
    end else if (w_snap && (r_state == StIdle)) begin
      r_snap_done <= r_done;
      for (int i = 0; i < CH_NUM; i++) begin
        r_snap_x[i] <= r_cnt_x[i];
        r_snap_s[i] <= r_cnt_s[i];
      end
    end
  end

  // Divider sequencer: LOAD, DIV_W quotient steps, OUT, for each channel in turn.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state     <= StIdle;
      r_ch        <= '0;
      r_bit       <= '0;
      r_dvd       <= '0;
      r_rem       <= '0;
      r_dvs       <= '0;
      r_err       <= 1'b0;
      r_freq_data <= '0;
      r_freq_ch   <= '0;
      r_freq_err  <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_snap) begin
            r_state <= StLoad;
            r_ch    <= '0;
          end
        end
        StLoad: begin
          r_dvd   <= w_dividend;
          r_dvs   <= r_snap_s[w_idx];
          r_rem   <= '0;
          r_bit   <= '0;
          r_err   <= !r_snap_done[w_idx] || (r_snap_s[w_idx] == '0);
          r_state <= StDiv;
        end
        StDiv: begin
          r_dvd <= w_quo_nxt;
          r_rem <= w_rem_nxt;
          r_bit <= r_bit + BIT_W'(1);
          if (r_bit == BIT_W'(DIV_W - 1)) begin
            r_state     <= StOut;
            r_freq_ch   <= r_ch;
            r_freq_err  <= r_err;
            r_freq_data <= r_err ? '0 : w_freq;
          end
        end
        default: begin
          if (r_ch == 4'(CH_NUM - 1)) begin
            r_state <= StIdle;
          end else begin
            r_ch    <= r_ch + 4'd1;
            r_state <= StLoad;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cymometer_multi.sv
// Bench for cymometer_multi: directed per-period stimulus configurations, a behavioural
// model predicting every output on every cycle, and hand-computed literal expectations.
module tb_cymometer_multi;

  localparam int CH  = 4;
  localparam int P   = 1500;
  localparam int SEQ = 66;
  localparam longint unsigned CLK_HZ = 50_000_000;

  logic          sys_clk   = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic [CH-1:0] clk_fx    = '0;

  logic [31:0] freq_data;
  logic [3:0]  freq_ch;
  logic        freq_vld, freq_err, busy;
  logic [19:0] n_data;
  logic [3:0]  n_ch;
  logic        n_vld, n_err, n_busy;

  cymometer_multi #(
    .CH_NUM(4), .CLK_FS_FREQ(50_000_000), .GATE_CYCLES(1000), .PERIOD_CYCLES(1500),
    .CNT_W(32), .DIV_W(64), .FREQ_W(32)
  ) u_dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .clk_fx(clk_fx),
    .freq_data(freq_data), .freq_ch(freq_ch), .freq_vld(freq_vld),
    .freq_err(freq_err), .busy(busy)
  );

  cymometer_multi #(
    .CH_NUM(4), .CLK_FS_FREQ(50_000_000), .GATE_CYCLES(1000), .PERIOD_CYCLES(1500),
    .CNT_W(32), .DIV_W(64), .FREQ_W(20)
  ) u_dut_w20 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .clk_fx(clk_fx),
    .freq_data(n_data), .freq_ch(n_ch), .freq_vld(n_vld),
    .freq_err(n_err), .busy(n_busy)
  );

  always #5 sys_clk = ~sys_clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stimulus configuration: fx period in sys_clk cycles per channel (0 = held low),
  // and a ch0 mode where ch0 stops after period cycle 500.
  int cfg_t[CH];
  bit cfg_win;
  int meas_t[CH];
  bit meas_win;

  // Model state.
  bit              m_init = 1'b0;
  int              m_cnt = 0;
  int              m_seq_t = -1;  // cycles since an accepted snapshot, -1 when idle
  int              g = 0;
  bit              f0 = 1'b0;
  longint unsigned r_data[CH], r_data20[CH];
  bit              r_err[CH];
  longint unsigned h_data = 0, h_data20 = 0;
  int              h_ch = 0;
  bit              h_err = 1'b0;

  function automatic longint unsigned exp_freq(input int t);
`ifdef CYMO_ROUND_EN
    return (CLK_HZ + longint'(t / 2)) / longint'(t);
`else
    return CLK_HZ / longint'(t);
`endif
  endfunction

  function automatic longint unsigned sat(input longint unsigned q, input int w);
    longint unsigned mx = (64'd1 << w) - 1;
    return (q > mx) ? mx : q;
  endfunction

  // Model: period position, snapshot acceptance, result schedule; also drives clk_fx.
  initial begin
    bit was_snap, was_busy, wave;
    int k;
    forever begin
      @(posedge sys_clk);
      if (!sys_rst_n) begin
        m_init = 1'b1; m_cnt = 0; m_seq_t = -1; g = 0; f0 = 1'b0;
        h_data = 0; h_data20 = 0; h_ch = 0; h_err = 1'b0;
        meas_t = cfg_t; meas_win = cfg_win;
      end else begin
        was_snap = (m_cnt == P - 1);
        was_busy = (m_seq_t >= 1);
        if (m_seq_t >= 1) begin
          m_seq_t++;
          if (m_seq_t > CH * SEQ) m_seq_t = -1;
        end
        if (was_snap && !was_busy) begin
          m_seq_t = 1;
          for (int i = 0; i < CH; i++) begin
            if (meas_t[i] == 0 || (i == 0 && meas_win)) begin
              r_data[i] = 0; r_data20[i] = 0; r_err[i] = 1'b1;
            end else begin
              r_data[i]   = sat(exp_freq(meas_t[i]), 32);
              r_data20[i] = sat(exp_freq(meas_t[i]), 20);
              r_err[i]    = 1'b0;
            end
          end
        end
        m_cnt = was_snap ? 0 : m_cnt + 1;
        if (m_cnt == 0) begin
          meas_t = cfg_t; meas_win = cfg_win;
        end
        if (m_seq_t > 0 && (m_seq_t % SEQ) == 0) begin
          k = m_seq_t / SEQ - 1;
          h_data = r_data[k]; h_data20 = r_data20[k]; h_ch = k; h_err = r_err[k];
        end
        g++;
      end
      #1;
      for (int i = 0; i < CH; i++) begin
        wave = (cfg_t[i] != 0) && ((g % cfg_t[i]) >= cfg_t[i] / 2);
        if (i == 0) begin
          // Release the ch0 hold only while the waveform is low, so every edge is regular.
          if (meas_win && m_cnt > 500) f0 = 1'b1;
          else if (!wave)              f0 = 1'b0;
          clk_fx[i] = wave && !f0;
        end else begin
          clk_fx[i] = wave;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (m_init) begin
        chk("vld", {63'd0, freq_vld}, {63'd0, (m_seq_t > 0 && (m_seq_t % SEQ) == 0)});
        chk("busy", {63'd0, busy}, {63'd0, (m_seq_t >= 1)});
        chk("data", {32'd0, freq_data}, h_data);
        chk("ch", {60'd0, freq_ch}, 64'(h_ch));
        chk("err", {63'd0, freq_err}, {63'd0, h_err});
        chk("vld_w20", {63'd0, n_vld}, {63'd0, (m_seq_t > 0 && (m_seq_t % SEQ) == 0)});
        chk("data_w20", {44'd0, n_data}, h_data20);
        chk("err_w20", {63'd0, n_err}, {63'd0, h_err});
      end
    end
  end

  task automatic wait_seq(input int s);
    int n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (m_seq_t != s && n < 5000);
    if (m_seq_t != s) begin
      n_chk++; n_fail++;
      $display("FAIL wait_seq: seq %0d not reached, at %0d", s, m_seq_t);
    end
  endtask

  task automatic wait_cnt(input int c);
    int n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (m_cnt != c && n < 5000);
    if (m_cnt != c) begin
      n_chk++; n_fail++;
      $display("FAIL wait_cnt: cnt %0d not reached, at %0d", c, m_cnt);
    end
  endtask

  task automatic lit(input string name, input int ch, input longint unsigned data, input bit err);
    chk({name, "_vld"}, {63'd0, freq_vld}, 64'd1);
    chk({name, "_ch"}, {60'd0, freq_ch}, 64'(ch));
    chk({name, "_data"}, {32'd0, freq_data}, data);
    chk({name, "_err"}, {63'd0, freq_err}, {63'd0, err});
  endtask

  initial begin
    cfg_t = '{10, 0, 0, 0}; cfg_win = 1'b0;
    repeat (5) @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // Period 1 measures ch0 period 10 only.
    wait_cnt(1200);
    cfg_t = '{10, 20, 4, 0};
    wait_seq(66);
    lit("t1_ch0", 0, 64'd5_000_000, 1'b0);
    chk("t4_data_w20", {44'd0, n_data}, 64'hF_FFFF);
    chk("t4_err_w20", {63'd0, n_err}, 64'd0);
    wait_seq(132);
    lit("t1_ch1", 1, 64'd0, 1'b1);

    // Period 2 measures four channels.
    wait_cnt(1200);
    cfg_t = '{3, 0, 0, 0};
    wait_seq(66);
    lit("t2_ch0", 0, 64'd5_000_000, 1'b0);
    wait_seq(132);
    lit("t2_ch1", 1, 64'd2_500_000, 1'b0);
    wait_seq(198);
    lit("t2_ch2", 2, 64'd12_500_000, 1'b0);
    wait_seq(264);
    lit("t2_ch3", 3, 64'd0, 1'b1);

    // Period 3 measures ch0 period 3.
    wait_cnt(1200);
    cfg_t = '{10, 0, 0, 0}; cfg_win = 1'b1;
    wait_seq(66);
`ifdef CYMO_ROUND_EN
    lit("t3_ch0", 0, 64'd16_666_667, 1'b0);
`else
    lit("t3_ch0", 0, 64'd16_666_666, 1'b0);
`endif

    // Period 4: ch0 stops at cycle 500, its gate never closes.
    wait_cnt(1200);
    cfg_t = '{10, 20, 4, 0}; cfg_win = 1'b0;
    wait_seq(66);
    lit("t6_ch0", 0, 64'd0, 1'b1);

    // Period 5 results: abort during ch1's division with a one-cycle reset.
    wait_seq(66);
    lit("t5_pre_ch0", 0, 64'd5_000_000, 1'b0);
    wait_seq(100);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    chk("t5_busy", {63'd0, busy}, 64'd0);
    chk("t5_data", {32'd0, freq_data}, 64'd0);
    chk("t5_vld", {63'd0, freq_vld}, 64'd0);

    // First full period after the reset reports correctly.
    wait_seq(132);
    lit("t5_post_ch1", 1, 64'd2_500_000, 1'b0);
    wait_seq(264);
    lit("t5_post_ch3", 3, 64'd0, 1'b1);
    repeat (5) @(negedge sys_clk);

    $display("Result: errors=%0d of %0d checks", n_fail, n_chk);
    $finish;
  end

endmodule
